instr_decode: RTL and testbench

Decode and issue stage of the RISC-Z pipeline, directly upstream of the register file. It accepts 16-bit instructions from fetch and splits them into source/destination register indices, write-enable, opcode and immediate. These fields drive the register file's read ports, and RegW/RD travel on to writeback. A 16-entry pending-write scoreboard stalls issue on register hazards until writeback retires the producing instruction.

---
 rtl/riscz_pkg.sv | 55 +++++
 rtl/instr_decode_if.sv | 30 +++
 rtl/riscz_scoreboard.sv | 44 ++++
 rtl/instr_decode.sv | 72 +++++++
 tb/tb_instr_decode.sv | 246 ++++++++++++++++++++++++
 5 files changed

// File: rtl/riscz_pkg.sv
// RISC-Z shared definitions: opcodes, instruction field positions and
// per-opcode register usage classes used by decode and the scoreboard.
package riscz_pkg;

    localparam int XLEN  = 16;
    localparam int NREGS = 16;

    // instruction field positions
    localparam int OP_HI = 15;
    localparam int OP_LO = 12;
    localparam int RD_HI = 11;
    localparam int RD_LO = 8;
    localparam int R1_HI = 7;
    localparam int R1_LO = 4;
    localparam int R2_HI = 3;
    localparam int R2_LO = 0;

    typedef enum logic [3:0] {
        OP_ADD  = 4'h0, OP_SUB = 4'h1, OP_AND = 4'h2, OP_OR   = 4'h3,
        OP_XOR  = 4'h4, OP_SLL = 4'h5, OP_SRL = 4'h6, OP_ADDI = 4'h7,
        OP_LI   = 4'h8, OP_LD  = 4'h9, OP_ST  = 4'hA, OP_BEQ  = 4'hB,
        OP_JMP  = 4'hC, OP_OUT = 4'hD, OP_NOP = 4'hE, OP_HALT = 4'hF
    } opcode_e;

    // ALU ops, ADDI, LI and LD produce a register result
    function automatic logic writes_rd(input logic [3:0] op);
        return op <= OP_LD;
    endfunction

    function automatic logic reads_r1(input logic [3:0] op);
        return (op <= OP_ADDI) || (op == OP_LD) || (op == OP_ST) || (op == OP_BEQ);
    endfunction

    function automatic logic reads_r2(input logic [3:0] op);
        return op <= OP_SRL;
    endfunction

    // store data, compare operand and OUT value all come from the RD field
    function automatic logic reads_rd(input logic [3:0] op);
        return (op == OP_ST) || (op == OP_BEQ) || (op == OP_OUT);
    endfunction

    function automatic logic [XLEN-1:0] ext_imm(input logic [15:0] instr);
        logic [XLEN-1:0] imm;
        case (instr[OP_HI:OP_LO])
            OP_ADDI, OP_LD, OP_ST, OP_BEQ:
                imm = {{(XLEN-4){instr[R2_HI]}}, instr[R2_HI:R2_LO]};
            OP_LI:  imm = {{(XLEN-8){1'b0}}, instr[R1_HI:R2_LO]};
            OP_JMP: imm = {{(XLEN-12){1'b0}}, instr[RD_HI:R2_LO]};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/instr_decode_if.sv
// Fetch-side, execute-side and writeback-retire signals of the decode stage.
// master = surrounding pipeline, slave = instr_decode.
interface instr_decode_if;
    import riscz_pkg::*;

    logic            in_valid;
    logic            in_ready;
    logic [15:0]     in_instr;
    logic            out_valid;
    logic            out_ready;
    logic [3:0]      R1;
    logic [3:0]      R2;
    logic [3:0]      RD;
    logic            RegW;
    logic [3:0]      op;
    logic [XLEN-1:0] imm;
    logic            wb_valid;
    logic [3:0]      wb_rd;

    modport master (
        output in_valid, in_instr, out_ready, wb_valid, wb_rd,
        input  in_ready, out_valid, R1, R2, RD, RegW, op, imm
    );

    modport slave (
        input  in_valid, in_instr, out_ready, wb_valid, wb_rd,
        output in_ready, out_valid, R1, R2, RD, RegW, op, imm
    );

endinterface

// File: rtl/riscz_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, set on issue
// of a writer, cleared on writeback retire. Only built with RISCZ_SCOREBOARD_EN.
`ifdef RISCZ_SCOREBOARD_EN
module riscz_scoreboard #(
    parameter int NREGS = riscz_pkg::NREGS
) (
    input  logic                           clk,
    input  logic                           reset,
    input  logic                           enable,
    input  logic                           set_en,
    input  logic [$clog2(NREGS)-1:0]       set_idx,
    input  logic                           clr_en,
    input  logic [$clog2(NREGS)-1:0]       clr_idx,
    input  logic [2:0]                     q_en,
    input  logic [2:0][$clog2(NREGS)-1:0]  q_idx,
    output logic                           hazard
);
    logic [NREGS-1:0] pending;
    logic [NREGS-1:0] pend_eff;

    // a register retiring this cycle no longer blocks issue
    always_comb begin
        pend_eff = pending;
        if (clr_en) pend_eff[clr_idx] = 1'b0;
    end

    // hazard if any enabled query index is still pending
    always_comb begin
        hazard = 1'b0;
        for (int i = 0; i < 3; i++)
            if (q_en[i] && pend_eff[q_idx[i]]) hazard = 1'b1;
    end

    // clear first, then set, so a same-index set wins
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pending <= '0;
        end else if (enable) begin
            if (clr_en) pending[clr_idx] <= 1'b0;
            if (set_en) pending[set_idx] <= 1'b1;
        end
    end
endmodule
`endif

// File: rtl/instr_decode.sv
// RISC-Z decode/issue stage. Splits 16-bit instructions into register-file
// indices, opcode and immediate behind a one-entry output register.
// RISC_Z hazard scoreboard is included when RISCZ_SCOREBOARD_EN is defined;
// otherwise hazards are left to software NOP padding.
module instr_decode
    import riscz_pkg::*;
(
    input  logic         clk,
    input  logic         reset,
    input  logic         enable,
    instr_decode_if.slave bus,
    output logic         halted,
    output logic         stall
);
    logic [3:0] f_op, f_rd, f_r1, f_r2;
    logic       hazard;
    logic       accept;

    assign f_op = bus.in_instr[OP_HI:OP_LO];
    assign f_rd = bus.in_instr[RD_HI:RD_LO];
    assign f_r1 = bus.in_instr[R1_HI:R1_LO];
    assign f_r2 = bus.in_instr[R2_HI:R2_LO];

`ifdef RISCZ_SCOREBOARD_EN
    riscz_scoreboard #(.NREGS(NREGS)) u_sb (
        .clk     (clk),
        .reset   (reset),
        .enable  (enable),
        .set_en  (accept & writes_rd(f_op)),
        .set_idx (f_rd),
        .clr_en  (bus.wb_valid),
        .clr_idx (bus.wb_rd),
        .q_en    ({reads_rd(f_op) | writes_rd(f_op), reads_r2(f_op), reads_r1(f_op)}),
        .q_idx   ({f_rd, f_r2, f_r1}),
        .hazard  (hazard)
    );
`else
    assign hazard = 1'b0;
`endif

    assign bus.in_ready = enable & ~halted & ~hazard & (~bus.out_valid | bus.out_ready);
    assign accept       = bus.in_valid & bus.in_ready;
    assign stall        = bus.in_valid & enable & ~halted & hazard;

    // output register: load on accept, drop valid on consume, hold otherwise
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            bus.out_valid <= 1'b0;
            bus.RegW      <= 1'b0;
            bus.op        <= '0;
            bus.RD        <= '0;
            bus.R1        <= '0;
            bus.R2        <= '0;
            bus.imm       <= '0;
            halted        <= 1'b0;
        end else if (enable) begin
            if (accept) begin
                bus.out_valid <= 1'b1;
                bus.RegW      <= writes_rd(f_op);
                bus.op        <= f_op;
                bus.RD        <= f_rd;
                bus.R1        <= f_r1;
                bus.R2        <= f_r2;
                bus.imm       <= ext_imm(bus.in_instr);
                if (f_op == OP_HALT) halted <= 1'b1;
            end else if (bus.out_ready) begin
                bus.out_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_instr_decode.sv
// Testbench for instr_decode: directed steps plus randomized traffic checked
// against a behavioural model of the decode rules and scoreboard.
module tb_instr_decode;
    logic clk = 1'b0;
    logic reset = 1'b0;
    logic enable = 1'b1;
    logic halted, stall;
    int   vectors = 0;
    int   miscompares = 0;

    instr_decode_if bus();

    instr_decode dut (
        .clk    (clk),
        .reset  (reset),
        .enable (enable),
        .bus    (bus),
        .halted (halted),
        .stall  (stall)
    );

    always #5 clk = ~clk;

    // behavioural model state
`ifdef RISCZ_SCOREBOARD_EN
    bit m_pend [16];
`endif
    bit m_halted, m_ov, m_regw;
    int m_op, m_rd, m_r1, m_r2, m_imm;

    function automatic bit m_writes(int op); return op <= 9; endfunction
    function automatic bit m_rd1(int op);    return (op <= 7) || (op >= 9 && op <= 11); endfunction
    function automatic bit m_rd2(int op);    return op <= 6; endfunction
    function automatic bit m_rdd(int op);    return op == 10 || op == 11 || op == 13; endfunction

    function automatic int m_immf(int ins);
        int op = ins >> 12;
        int v;
        case (op)
            7, 9, 10, 11: begin v = ins & 15; return (v >= 8) ? v - 16 + 65536 : v; end
            8:  return ins & 255;
            12: return ins & 4095;
            default: return 0;
        endcase
    endfunction

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_outputs();
        check("out_valid", bus.out_valid, m_ov);
        check("halted",    halted,        m_halted);
        check("RegW",      bus.RegW,      m_regw);
        check("op",        bus.op,        m_op);
        check("RD",        bus.RD,        m_rd);
        check("R1",        bus.R1,        m_r1);
        check("R2",        bus.R2,        m_r2);
        check("imm",       bus.imm,       m_imm);
    endtask

    task automatic model_clear();
`ifdef RISCZ_SCOREBOARD_EN
        foreach (m_pend[i]) m_pend[i] = 0;
`endif
        m_halted = 0; m_ov = 0; m_regw = 0;
        m_op = 0; m_rd = 0; m_r1 = 0; m_r2 = 0; m_imm = 0;
    endtask

    task automatic drive(bit v, logic [15:0] ins, bit ordy, bit wv, logic [3:0] wr);
        bus.in_valid  = v;
        bus.in_instr  = ins;
        bus.out_ready = ordy;
        bus.wb_valid  = wv;
        bus.wb_rd     = wr;
    endtask

    // one clock: check handshake before the edge, advance model, check outputs
    task automatic cycle();
        int  ins, op;
        bit  hz, rdy, stl, acc, en, ordy;
`ifdef RISCZ_SCOREBOARD_EN
        bit  eff [16];
        bit  wbv;
        int  wbr;
`endif
        @(negedge clk);
        ins  = int'(bus.in_instr);
        op   = ins >> 12;
        en   = enable;
        ordy = bus.out_ready;
        hz   = 0;
`ifdef RISCZ_SCOREBOARD_EN
        wbv = bus.wb_valid;
        wbr = int'(bus.wb_rd);
        eff = m_pend;
        if (wbv) eff[wbr] = 0;
        hz = (m_rd1(op) && eff[(ins >> 4) & 15]) || (m_rd2(op) && eff[ins & 15]) ||
             ((m_rdd(op) || m_writes(op)) && eff[(ins >> 8) & 15]);
`endif
        rdy = en && !m_halted && !hz && (!m_ov || ordy);
        stl = bus.in_valid && en && !m_halted && hz;
        check("in_ready", bus.in_ready, rdy);
        check("stall", stall, stl);
        acc = bus.in_valid && rdy;
        @(posedge clk);
        #1;
        if (en) begin
            if (acc) begin
                m_ov = 1; m_op = op; m_rd = (ins >> 8) & 15; m_r1 = (ins >> 4) & 15;
                m_r2 = ins & 15; m_regw = m_writes(op); m_imm = m_immf(ins);
                if (op == 15) m_halted = 1;
            end else if (ordy) begin
                m_ov = 0;
            end
`ifdef RISCZ_SCOREBOARD_EN
            if (wbv) m_pend[wbr] = 0;
            if (acc && m_writes(op)) m_pend[(ins >> 8) & 15] = 1;
`endif
        end
        check_outputs();
    endtask

    // asynchronous reset between edges, checked before the next clock edge
    task automatic do_reset();
        @(negedge clk);
        #2;
        reset = 1'b0;
        #1;
        model_clear();
        check_outputs();
        check("stall_in_reset", stall, 1'b0);
        @(posedge clk);
        #1;
        check_outputs();
        reset = 1'b1;
    endtask

    initial begin
        int ins;
        bit wv;
        logic [3:0] wr;
        model_clear();
        drive(0, 16'h0000, 0, 0, 4'h0);
        repeat (2) @(posedge clk);
        #1;
        check_outputs();
        check("rst_out_valid", bus.out_valid, 1'b0);
        check("rst_halted", halted, 1'b0);
        reset = 1'b1;

        // LI r3,5
        drive(1, 16'h8305, 1, 0, 4'h0); cycle();
        check("li_rd", bus.RD, 4'd3);
        check("li_regw", bus.RegW, 1'b1);
        check("li_imm", bus.imm, 16'h0005);
        check("li_op", bus.op, 4'h8);

        // ADD r1,r3,r2 hazards on r3 until writeback retires it
        drive(1, 16'h0132, 1, 0, 4'h0); cycle();
`ifdef RISCZ_SCOREBOARD_EN
        check("add_stall", stall, 1'b1);
        check("add_blocked", bus.in_ready, 1'b0);
`endif
        drive(1, 16'h0132, 1, 1, 4'h3); cycle();
        check("add_r1", bus.R1, 4'd3);
        check("add_r2", bus.R2, 4'd2);
        check("add_op", bus.op, 4'h0);

        // ADDI r2,r2,-1
        drive(1, 16'h722F, 1, 0, 4'h0); cycle();
        check("addi_imm", bus.imm, 16'hFFFF);
        check("addi_regw", bus.RegW, 1'b1);
        check("addi_r1", bus.R1, 4'd2);

        // downstream back-pressure for three cycles
        drive(1, 16'hE000, 0, 0, 4'h0);
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_hold_op", bus.op, 4'h7);
            check("bp_ready", bus.in_ready, 1'b0);
        end
        drive(1, 16'hE000, 1, 0, 4'h0); cycle();
        check("bp_release_op", bus.op, 4'hE);

        // randomized traffic, HALT excluded
        for (int n = 0; n < 400; n++) begin
            ins = int'($urandom_range(0, 65535));
            if ((ins >> 12) == 15) ins = ins & 16'hEFFF;
            wv = 0; wr = 4'($urandom_range(0, 15));
`ifdef RISCZ_SCOREBOARD_EN
            if ($urandom_range(0, 1) == 1) begin
                int s = $urandom_range(0, 15);
                for (int k = 0; k < 16; k++)
                    if (!wv && m_pend[(s + k) % 16]) begin wv = 1; wr = 4'((s + k) % 16); end
            end
`else
            wv = ($urandom_range(0, 3) == 0);
`endif
            enable = ($urandom_range(0, 9) != 0);
            drive($urandom_range(0, 3) != 0, 16'(ins), $urandom_range(0, 3) != 0, wv, wr);
            cycle();
        end
        enable = 1'b1;

        // reset while stalled clears the scoreboard
        do_reset();
        drive(1, 16'h8505, 1, 0, 4'h0); cycle();
        drive(1, 16'h0155, 1, 0, 4'h0); cycle();
        do_reset();
        cycle();
        check("post_rst_accept_op", bus.op, 4'h0);

        // HALT
        drive(1, 16'hF000, 1, 0, 4'h0); cycle();
        check("halt_valid", bus.out_valid, 1'b1);
        check("halt_regw", bus.RegW, 1'b0);
        check("halt_flag", halted, 1'b1);
        drive(1, 16'hE000, 1, 0, 4'h0);
        for (int i = 0; i < 2; i++) begin
            cycle();
            check("halt_ready", bus.in_ready, 1'b0);
        end
        do_reset();
        check("halt_rst_flag", halted, 1'b0);
        check("halt_rst_valid", bus.out_valid, 1'b0);

        // LI r3 then ADD reading r3 back-to-back
        drive(1, 16'h8305, 1, 0, 4'h0); cycle();
        drive(1, 16'h0132, 1, 0, 4'h0); cycle();
`ifndef RISCZ_SCOREBOARD_EN
        check("b2b_valid", bus.out_valid, 1'b1);
        check("b2b_op", bus.op, 4'h0);
        check("b2b_stall", stall, 1'b0);
`endif
        drive(0, 16'h0000, 1, 0, 4'h0); cycle();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
